// File: rtl/uart_msg_scheduler.sv
// uart_msg_scheduler
//   Sequences the uart core's FIFO ports for the game logic.
//   Tx side: game_over (rising edge -> CHAR_OVER) and player_ready (one
//   CHAR_READY per READY_PERIOD cycles held) share one tx write port with
//   fixed priority to game_over. Pushes go IDLE -> WRITE -> GAP, so a push
//   happens at most once every 3 cycles.
//   Rx side: pops the rx FIFO one byte at a time and presents it on
//   rx_byte with a one-cycle rx_valid pulse.
// Ports
//   clk, rst          clock, async active-low reset
//   game_over         game FSM level, clk-synchronous
//   player_ready      game FSM level, clk-synchronous
//   tx_full           uart tx FIFO full
//   rx_empty, r_data  uart rx FIFO empty flag / head byte
//   wr_uart, w_data   tx FIFO push strobe / byte
//   rd_uart           rx FIFO pop strobe
//   rx_byte, rx_valid last received byte / one-cycle update pulse
//   busy              a tx request is pending or being issued
module uart_msg_scheduler #(
  parameter int unsigned READY_PERIOD = 65_000_000,
  parameter logic [7:0]  CHAR_OVER    = 8'h4C,
  parameter logic [7:0]  CHAR_READY   = 8'h52
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_over,
  input  logic       player_ready,
  input  logic       tx_full,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       rd_uart,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       busy
);

  localparam int unsigned CW = $clog2(READY_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(READY_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  state_t          state, state_nxt;
  logic            go_prev;
  logic            pend_over, pend_ready;
  logic [CW-1:0]   cnt;
  logic            wr_nxt;
  logic [7:0]      wdata_nxt;
  logic            clr_over, clr_ready;
  logic            ready_run, wrap, pop;
  logic [7:0]      cap;

  assign ready_run = player_ready & ~game_over;
  assign wrap      = ready_run & (cnt == LAST);
  // Pop at most every other cycle so the FIFO head has updated before the next pop.
  assign pop       = ~rx_empty & ~game_over & ~rd_uart;
  assign busy      = pend_over | pend_ready | (state != IDLE);

  // Tx FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Tx FSM next state and registered-output next values
  always_comb begin
    state_nxt = state;
    wr_nxt    = 1'b0;
    wdata_nxt = 8'h00;
    clr_over  = 1'b0;
    clr_ready = 1'b0;
    case (state)
      IDLE: begin
        if ((pend_over | pend_ready) & ~tx_full) begin
          state_nxt = WRITE;
          wr_nxt    = 1'b1;
          if (pend_over) begin
            wdata_nxt = CHAR_OVER;
            clr_over  = 1'b1;
          end else begin
            wdata_nxt = CHAR_READY;
            clr_ready = 1'b1;
          end
        end
      end
      WRITE:   state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pending requests, ready counter and tx outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      go_prev    <= 1'b0;
      pend_over  <= 1'b0;
      pend_ready <= 1'b0;
      cnt        <= '0;
      wr_uart    <= 1'b0;
      w_data     <= 8'h00;
    end else begin
      go_prev   <= game_over;
      // A fresh edge wins over a same-cycle issue so it is never lost.
      pend_over <= (game_over & ~go_prev) | (pend_over & ~clr_over);
      if (!ready_run) begin
        cnt        <= '0;
        pend_ready <= 1'b0;
      end else if (wrap) begin
        cnt        <= '0;
        pend_ready <= 1'b1;   // merges with an already pending 'R'
      end else begin
        cnt        <= cnt + 1'b1;
        pend_ready <= pend_ready & ~clr_ready;
      end
      wr_uart <= wr_nxt;
      w_data  <= wdata_nxt;
    end
  end

  // Rx drain: capture head byte with the pop, present it the cycle after.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_uart  <= 1'b0;
      cap      <= 8'h00;
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      rd_uart  <= pop;
      if (pop) cap <= r_data;
      rx_valid <= rd_uart;
      if (rd_uart) rx_byte <= cap;
    end
  end

endmodule

// File: tb/tb_uart_msg_scheduler.sv
// Testbench for uart_msg_scheduler (READY_PERIOD=8). Directed scenarios
// followed by random traffic; every cycle the outputs are compared with a
// behavioural model built from counters and a push cooldown.
module tb_uart_msg_scheduler;

  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       game_over = 1'b0, player_ready = 1'b0, tx_full = 1'b0;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       wr_uart, rd_uart, rx_valid, busy;
  logic [7:0] w_data, rx_byte;

  uart_msg_scheduler #(.READY_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .game_over(game_over), .player_ready(player_ready),
    .tx_full(tx_full), .rx_empty(rx_empty), .r_data(r_data),
    .wr_uart(wr_uart), .w_data(w_data), .rd_uart(rd_uart),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // environment: rx FIFO contents and logs of observed traffic
  logic [7:0] q[$];
  logic [7:0] pushes[$];
  logic [7:0] rxlog[$];
  int         rd_cnt;

  // reference model state
  logic       m_go_prev, m_pover, m_pready, m_wr, m_rd, m_rxv;
  logic [7:0] m_wdata, m_cap, m_rxb;
  int         m_run, m_hold;

  task automatic m_reset();
    m_go_prev = 0; m_pover = 0; m_pready = 0; m_wr = 0; m_rd = 0; m_rxv = 0;
    m_wdata = 0; m_cap = 0; m_rxb = 0; m_run = 0; m_hold = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_rx();
    rx_empty = (q.size() == 0);
    r_data   = (q.size() == 0) ? 8'h00 : q[0];
  endtask

  // One clock: predict from current inputs, advance, then compare.
  task automatic cyc();
    logic go, rise, qual, push, pick_over, pop, do_pop;
    go        = game_over;
    rise      = game_over & ~m_go_prev;
    qual      = player_ready & ~game_over;
    push      = (m_hold == 0) && (m_pover || m_pready) && !tx_full;
    pick_over = m_pover;
    pop       = !rx_empty && !game_over && !m_rd;
    do_pop    = rd_uart;
    @(posedge clk);
    m_wr    = push;
    m_wdata = push ? (pick_over ? 8'h4C : 8'h52) : 8'h00;
    if (push) m_hold = 2;
    else if (m_hold != 0) m_hold--;
    m_pover = rise | (m_pover & ~(push & pick_over));
    if (!qual) begin
      m_run = 0; m_pready = 0;
    end else begin
      m_run++;
      if (m_run == RP) begin m_run = 0; m_pready = 1; end
      else if (push && !pick_over) m_pready = 0;
    end
    m_go_prev = go;
    m_rxv = m_rd;
    if (m_rd) m_rxb = m_cap;
    if (pop) m_cap = r_data;
    m_rd = pop;
    if (do_pop && q.size() > 0) void'(q.pop_front());
    #1;
    drive_rx();
    chk("wr_uart",  wr_uart,  m_wr);
    chk("w_data",   w_data,   m_wdata);
    chk("busy",     busy,     m_pover | m_pready | (m_hold != 0));
    chk("rd_uart",  rd_uart,  m_rd);
    chk("rx_valid", rx_valid, m_rxv);
    chk("rx_byte",  rx_byte,  m_rxb);
    if (wr_uart)  pushes.push_back(w_data);
    if (rx_valid) rxlog.push_back(rx_byte);
    if (rd_uart)  rd_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  function automatic int count_of(input logic [7:0] b);
    int c = 0;
    foreach (pushes[i]) if (pushes[i] == b) c++;
    return c;
  endfunction

  initial begin
    logic found;
    m_reset();
    rd_cnt = 0;

    // reset state
    #12;
    chk("rst_wr_uart",  wr_uart,  1'b0);
    chk("rst_w_data",   w_data,   8'h00);
    chk("rst_busy",     busy,     1'b0);
    chk("rst_rd_uart",  rd_uart,  1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_byte",  rx_byte,  8'h00);
    @(posedge clk); #1;
    rst = 1'b1;
    run(3);

    // 1: game_over edge -> one 'L' within 2 cycles, no repeat while high
    pushes.delete();
    game_over = 1;
    run(2);
    chk("t1_l_fast_cnt", pushes.size(), 1);
    chk("t1_l_byte", (pushes.size() > 0) ? pushes[0] : 8'hxx, 8'h4C);
    run(20);
    chk("t1_l_once", count_of(8'h4C), 1);
    game_over = 0;
    run(4);

    // 2: player_ready 40 cycles -> 5 'R'; short hold -> none
    pushes.delete();
    player_ready = 1;
    run(40);
    player_ready = 0;
    run(6);
    chk("t2_r_count", count_of(8'h52), 5);
    chk("t2_total", pushes.size(), 5);
    pushes.delete();
    player_ready = 1;
    run(5);
    player_ready = 0;
    run(12);
    chk("t2_short_none", pushes.size(), 0);

    // 3: ready pending behind tx_full, then game_over -> only 'L'
    pushes.delete();
    tx_full = 1; player_ready = 1;
    run(RP);
    game_over = 1;
    run(1);
    tx_full = 0;
    run(6);
    chk("t3_l_count", count_of(8'h4C), 1);
    chk("t3_r_none", count_of(8'h52), 0);
    chk("t3_busy_idle", busy, 1'b0);
    game_over = 0; player_ready = 0;
    run(3);

    // 4: tx_full blocks a pending 'L' for 20 cycles
    pushes.delete();
    tx_full = 1; game_over = 1;
    run(20);
    chk("t4_blocked", pushes.size(), 0);
    chk("t4_busy_held", busy, 1'b1);
    tx_full = 0;
    run(6);
    chk("t4_one_l", pushes.size(), 1);
    chk("t4_l_byte", count_of(8'h4C), 1);
    game_over = 0;
    run(3);

    // 5: rx drain, blocked while game_over
    rxlog.delete(); rd_cnt = 0;
    game_over = 1;
    q.push_back(8'hA5); q.push_back(8'h3C);
    drive_rx();
    run(6);
    chk("t5_no_pop_go", rd_cnt, 0);
    chk("t5_no_valid_go", rxlog.size(), 0);
    game_over = 0;
    run(8);
    chk("t5_pops", rd_cnt, 2);
    chk("t5_valid_cnt", rxlog.size(), 2);
    chk("t5_byte0", (rxlog.size() > 0) ? rxlog[0] : 8'hxx, 8'hA5);
    chk("t5_byte1", (rxlog.size() > 1) ? rxlog[1] : 8'hxx, 8'h3C);

    // 6: reset during WRITE drops the push
    found = 0;
    game_over = 1;
    for (int i = 0; i < 5 && !found; i++) begin
      cyc();
      if (wr_uart) found = 1;
    end
    chk("t6_write_seen", found, 1'b1);
    #1;
    rst = 0; game_over = 0;
    #1;
    chk("t6_wr_uart", wr_uart, 1'b0);
    chk("t6_w_data",  w_data,  8'h00);
    chk("t6_busy",    busy,    1'b0);
    #1;
    rst = 1;
    m_reset();
    pushes.delete();
    run(10);
    chk("t6_no_replay", pushes.size(), 0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) game_over = ~game_over;
      if ($urandom_range(0, 24) == 0) player_ready = ~player_ready;
      tx_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0 && q.size() < 16) q.push_back(8'($urandom));
      drive_rx();
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
